// File: rtl/mmio_timer_pkg.sv
// Shared constants for mmio_timer: register offsets, CONTROL bit indices,
// bus handshake state encoding and the default COMPARE reset value.
package mmio_timer_pkg;

    localparam logic [1:0] ADDR_COUNT    = 2'd0;
    localparam logic [1:0] ADDR_COMPARE  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL  = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTOCLR = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_PEND    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    localparam logic [31:0] COMPARE_RESET_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for mmio_timer: one tick every limit+1 enabled cycles.
// Used only when MMIO_TIMER_PRESCALER_EN is defined.
module timer_prescaler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] limit,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic        at_limit;

    assign at_limit = (cnt_q == limit);
    assign tick     = enable & at_limit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear || !enable || at_limit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer with COUNT/COMPARE/CONTROL/PRESCALE registers, four-phase
// Read/Write/Ack responder and level interrupt. Prescaler: MMIO_TIMER_PRESCALER_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for Read/Write; performs exactly one access on entry
// ST_ACK  | Ack high until the requester drops both Read and Write
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] COMPARE_RESET = COMPARE_RESET_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Read,
    input  logic        Write,
    input  logic [1:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ack,
    output logic        Interrupt
);

    bus_state_t  state_q, state_d;
    logic        access;
    logic        wr_en, rd_en;
    logic        wr_count, wr_compare, wr_control;
    logic [31:0] count_q, compare_q, rd_data;
    logic        en_q, autoclr_q, ie_q, pend_q;
    logic        tick, match;

    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Read || Write) begin
                    access  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!Read && !Write) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en      = access & Write;
    assign rd_en      = access & ~Write;
    assign wr_count   = wr_en & (Address == ADDR_COUNT);
    assign wr_compare = wr_en & (Address == ADDR_COMPARE);
    assign wr_control = wr_en & (Address == ADDR_CONTROL);
    assign Ack        = (state_q == ST_ACK);

`ifdef MMIO_TIMER_PRESCALER_EN
    logic [15:0] prescale_q;
    logic        wr_prescale;

    assign wr_prescale = wr_en & (Address == ADDR_PRESCALE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) prescale_q <= '0;
        else if (wr_prescale) prescale_q <= DataIn[15:0];
    end

    timer_prescaler u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (en_q),
        .clear   (wr_prescale),
        .limit   (prescale_q),
        .tick    (tick)
    );
`else
    assign tick = en_q;
`endif

    // Compare against the pre-update COUNT so the matched value is visible for one tick.
    assign match = tick & (count_q == compare_q);

    always_comb begin
        rd_data = '0;
        case (Address)
            ADDR_COUNT:   rd_data = count_q;
            ADDR_COMPARE: rd_data = compare_q;
            ADDR_CONTROL: rd_data = {28'd0, pend_q, ie_q, autoclr_q, en_q};
`ifdef MMIO_TIMER_PRESCALER_EN
            ADDR_PRESCALE: rd_data = {16'd0, prescale_q};
`endif
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            compare_q <= COMPARE_RESET;
            en_q      <= 1'b0;
            autoclr_q <= 1'b0;
            ie_q      <= 1'b0;
            pend_q    <= 1'b0;
            Interrupt <= 1'b0;
            DataOut   <= '0;
        end else begin
            state_q <= state_d;

            if (wr_count) count_q <= DataIn;
            else if (tick) count_q <= (match && autoclr_q) ? 32'd0 : count_q + 32'd1;

            if (wr_compare) compare_q <= DataIn;

            if (wr_control) begin
                en_q      <= DataIn[CTRL_EN];
                autoclr_q <= DataIn[CTRL_AUTOCLR];
                ie_q      <= DataIn[CTRL_IE];
            end

            if (match) pend_q <= 1'b1;
            else if (wr_control && DataIn[CTRL_PEND]) pend_q <= 1'b0;

            Interrupt <= pend_q & ie_q;

            // Writes echo the written word so a held request keeps a stable DataOut.
            if (wr_en) DataOut <= DataIn;
            else if (rd_en) DataOut <= rd_data;
        end
    end

endmodule
